// File: rtl/exu_lsu_pkg.sv
// exu_lsu_pkg -- shared definitions for the EX/MEM load-store unit.
// Holds the RV32 widths, the load/store opcodes, the funct3 access codes,
// the data-memory widths, the LSU state encoding and the lane helpers used
// to build byte enables and lane-positioned store data.
package exu_lsu_pkg;

  localparam int RV32_DATA_WIDTH   = 32;
  localparam int RV32_OPCODE_WIDTH = 7;
  localparam int RV32_FUNCT3_WIDTH = 3;
  localparam int DMEM_ADDR_WIDTH   = 32;
  localparam int DMEM_BE_WIDTH     = 4;

  localparam logic [RV32_OPCODE_WIDTH-1:0] RV32_OPCODE_LOAD  = 7'b0000011;
  localparam logic [RV32_OPCODE_WIDTH-1:0] RV32_OPCODE_STORE = 7'b0100011;

  localparam logic [RV32_FUNCT3_WIDTH-1:0] F3_LB  = 3'd0;
  localparam logic [RV32_FUNCT3_WIDTH-1:0] F3_LH  = 3'd1;
  localparam logic [RV32_FUNCT3_WIDTH-1:0] F3_LW  = 3'd2;
  localparam logic [RV32_FUNCT3_WIDTH-1:0] F3_LBU = 3'd4;
  localparam logic [RV32_FUNCT3_WIDTH-1:0] F3_LHU = 3'd5;
  localparam logic [RV32_FUNCT3_WIDTH-1:0] F3_SB  = 3'd0;
  localparam logic [RV32_FUNCT3_WIDTH-1:0] F3_SH  = 3'd1;
  localparam logic [RV32_FUNCT3_WIDTH-1:0] F3_SW  = 3'd2;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_REQ  = 2'd1,
    LSU_WAIT = 2'd2
  } lsu_state_e;

  // Byte enables of an access; funct3[1:0] encodes the size (byte/half/word).
  function automatic logic [DMEM_BE_WIDTH-1:0] access_be(
    input logic [RV32_FUNCT3_WIDTH-1:0] funct3,
    input logic [1:0]                   offset
  );
    logic [DMEM_BE_WIDTH-1:0] be;
    case (funct3[1:0])
      2'd0:    be = 4'b0001 << offset;
      2'd1:    be = 4'b0011 << offset;
      2'd2:    be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

  // Store data replicated across lanes so the enabled lanes carry it.
  function automatic logic [RV32_DATA_WIDTH-1:0] store_lanes(
    input logic [RV32_FUNCT3_WIDTH-1:0] funct3,
    input logic [RV32_DATA_WIDTH-1:0]   wdata
  );
    logic [RV32_DATA_WIDTH-1:0] lanes;
    case (funct3[1:0])
      2'd0:    lanes = {4{wdata[7:0]}};
      2'd1:    lanes = {2{wdata[15:0]}};
      2'd2:    lanes = wdata;
      default: lanes = 32'h0000_0000;
    endcase
    return lanes;
  endfunction

endpackage

// File: rtl/exu_lsu_load_align.sv
// lsu_load_align -- combinational load data aligner.
// Ports: i_rdata  raw memory word
//        i_offset address bits [1:0] of the load
//        i_funct3 load kind (LB/LH/LW/LBU/LHU)
//        o_rdata  selected lane, sign- or zero-extended to 32 bits
module lsu_load_align
  import exu_lsu_pkg::*;
(
  input  logic [RV32_DATA_WIDTH-1:0]   i_rdata,
  input  logic [1:0]                   i_offset,
  input  logic [RV32_FUNCT3_WIDTH-1:0] i_funct3,
  output logic [RV32_DATA_WIDTH-1:0]   o_rdata
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Pick the addressed lane, then extend according to the load kind.
  always_comb begin
    byte_s  = 8'h00;
    half_s  = 16'h0000;
    o_rdata = 32'h0000_0000;
    case (i_offset)
      2'd0:    byte_s = i_rdata[7:0];
      2'd1:    byte_s = i_rdata[15:8];
      2'd2:    byte_s = i_rdata[23:16];
      2'd3:    byte_s = i_rdata[31:24];
      default: byte_s = 8'h00;
    endcase
    if (i_offset[1]) begin
      half_s = i_rdata[31:16];
    end else begin
      half_s = i_rdata[15:0];
    end
    case (i_funct3)
      F3_LB:   o_rdata = {{24{byte_s[7]}}, byte_s};
      F3_LH:   o_rdata = {{16{half_s[15]}}, half_s};
      F3_LW:   o_rdata = i_rdata;
      F3_LBU:  o_rdata = {24'h00_0000, byte_s};
      F3_LHU:  o_rdata = {16'h0000, half_s};
      default: o_rdata = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/exu_lsu.sv
// exu_lsu -- EX/MEM load-store unit with a single outstanding data access.
// Ports: clk/rst_n           clock, synchronous active-low reset
//        i_valid/i_opcode/i_funct3/i_addr/i_wdata  instruction in the EX/MEM slot
//        o_stall             freeze the upstream pipeline
//        o_rdata/o_rdata_valid  aligned, extended load result
//        o_misalign          misaligned access flagged and dropped
//        o_dmem_*/i_dmem_*   data memory request/grant/response channel
// A request is raised combinationally in IDLE so stores granted at once
// cost no stall; a pending request replays the latched fields in REQ.
module exu_lsu
  import exu_lsu_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         i_valid,
  input  logic [RV32_OPCODE_WIDTH-1:0] i_opcode,
  input  logic [RV32_FUNCT3_WIDTH-1:0] i_funct3,
  input  logic [RV32_DATA_WIDTH-1:0]   i_addr,
  input  logic [RV32_DATA_WIDTH-1:0]   i_wdata,
  output logic                         o_stall,
  output logic [RV32_DATA_WIDTH-1:0]   o_rdata,
  output logic                         o_rdata_valid,
  output logic                         o_misalign,
  output logic                         o_dmem_req,
  output logic                         o_dmem_we,
  output logic [DMEM_ADDR_WIDTH-1:0]   o_dmem_addr,
  output logic [DMEM_BE_WIDTH-1:0]     o_dmem_be,
  output logic [RV32_DATA_WIDTH-1:0]   o_dmem_wdata,
  input  logic                         i_dmem_gnt,
  input  logic                         i_dmem_rvalid,
  input  logic [RV32_DATA_WIDTH-1:0]   i_dmem_rdata
);

  lsu_state_e                   state_r, state_nxt_s;
  logic [RV32_FUNCT3_WIDTH-1:0] funct3_r;
  logic                         we_r;
  logic [1:0]                   off_r;
  logic [DMEM_BE_WIDTH-1:0]     be_r;
  logic [RV32_DATA_WIDTH-1:0]   wdata_r;
  logic [DMEM_ADDR_WIDTH-3:0]   addr_r;

  logic                         is_load_s, is_store_s, legal_s, misal_s;
  logic                         start_s, flag_misalign_s;
  logic [DMEM_BE_WIDTH-1:0]     new_be_s;
  logic [RV32_DATA_WIDTH-1:0]   new_wdata_s, aligned_s;

  // Decode the slot: legality, alignment and the lane-positioned fields.
  always_comb begin
    is_load_s  = (i_opcode == RV32_OPCODE_LOAD);
    is_store_s = (i_opcode == RV32_OPCODE_STORE);
    legal_s    = (is_load_s  && ((i_funct3 == F3_LB) || (i_funct3 == F3_LH) ||
                                 (i_funct3 == F3_LW) || (i_funct3 == F3_LBU) ||
                                 (i_funct3 == F3_LHU))) ||
                 (is_store_s && ((i_funct3 == F3_SB) || (i_funct3 == F3_SH) ||
                                 (i_funct3 == F3_SW)));
    // funct3[1:0] is the size for every legal code, signed or not.
    misal_s    = ((i_funct3[1:0] == 2'd1) && i_addr[0]) ||
                 ((i_funct3[1:0] == 2'd2) && (i_addr[1:0] != 2'b00));
    start_s         = i_valid && legal_s && !misal_s;
    flag_misalign_s = i_valid && legal_s && misal_s;
    new_be_s        = access_be(i_funct3, i_addr[1:0]);
    new_wdata_s     = store_lanes(i_funct3, i_wdata);
  end

  lsu_load_align u_load_align (
    .i_rdata  (i_dmem_rdata),
    .i_offset (off_r),
    .i_funct3 (funct3_r),
    .o_rdata  (aligned_s)
  );

  // Next-state and output decode; reset forces every output to zero.
  always_comb begin
    state_nxt_s   = state_r;
    o_stall       = 1'b0;
    o_misalign    = 1'b0;
    o_dmem_req    = 1'b0;
    o_dmem_we     = 1'b0;
    o_dmem_addr   = 32'h0000_0000;
    o_dmem_be     = 4'b0000;
    o_dmem_wdata  = 32'h0000_0000;
    o_rdata_valid = 1'b0;
    o_rdata       = 32'h0000_0000;
    if (!rst_n) begin
      state_nxt_s = LSU_IDLE;
    end else begin
      case (state_r)
        LSU_IDLE: begin
          if (start_s) begin
            o_dmem_req   = 1'b1;
            o_dmem_we    = is_store_s;
            o_dmem_addr  = {i_addr[31:2], 2'b00};
            o_dmem_be    = new_be_s;
            o_dmem_wdata = new_wdata_s;
            if (i_dmem_gnt) begin
              if (is_store_s) begin
                state_nxt_s = LSU_IDLE;
              end else begin
                state_nxt_s = LSU_WAIT;
                o_stall     = 1'b1;
              end
            end else begin
              state_nxt_s = LSU_REQ;
              o_stall     = 1'b1;
            end
          end else if (flag_misalign_s) begin
            o_misalign = 1'b1;
          end else begin
            state_nxt_s = LSU_IDLE;
          end
        end
        LSU_REQ: begin
          o_dmem_req   = 1'b1;
          o_dmem_we    = we_r;
          o_dmem_addr  = {addr_r, 2'b00};
          o_dmem_be    = be_r;
          o_dmem_wdata = wdata_r;
          if (i_dmem_gnt) begin
            if (we_r) begin
              state_nxt_s = LSU_IDLE;
            end else begin
              state_nxt_s = LSU_WAIT;
              o_stall     = 1'b1;
            end
          end else begin
            o_stall = 1'b1;
          end
        end
        LSU_WAIT: begin
          if (i_dmem_rvalid) begin
            o_rdata_valid = 1'b1;
            o_rdata       = aligned_s;
            state_nxt_s   = LSU_IDLE;
          end else begin
            o_stall = 1'b1;
          end
        end
        default: begin
          state_nxt_s = LSU_IDLE;
        end
      endcase
    end
  end

  // State register and access latch, captured only when IDLE starts an access.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r  <= LSU_IDLE;
      funct3_r <= 3'd0;
      we_r     <= 1'b0;
      off_r    <= 2'd0;
      be_r     <= 4'b0000;
      wdata_r  <= 32'h0000_0000;
      addr_r   <= 30'd0;
    end else begin
      state_r <= state_nxt_s;
      if ((state_r == LSU_IDLE) && start_s) begin
        funct3_r <= i_funct3;
        we_r     <= is_store_s;
        off_r    <= i_addr[1:0];
        be_r     <= new_be_s;
        wdata_r  <= new_wdata_s;
        addr_r   <= i_addr[31:2];
      end
    end
  end

endmodule

// File: tb/tb_exu_lsu.sv
// tb_exu_lsu -- randomized scoreboard bench for exu_lsu.
// The driver classifies each access with plain arithmetic, pushes the
// expected memory-side and load-result events into a queue, and checks
// per-cycle stall/request timing; a negedge monitor pops and compares.
module tb_exu_lsu;
  import exu_lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_valid = 1'b0;
  logic [6:0]  i_opcode = 7'd0;
  logic [2:0]  i_funct3 = 3'd0;
  logic [31:0] i_addr = 32'd0;
  logic [31:0] i_wdata = 32'd0;
  logic        o_stall, o_rdata_valid, o_misalign, o_dmem_req, o_dmem_we;
  logic [31:0] o_rdata, o_dmem_addr, o_dmem_wdata;
  logic [3:0]  o_dmem_be;
  logic        i_dmem_gnt = 1'b0;
  logic        i_dmem_rvalid = 1'b0;
  logic [31:0] i_dmem_rdata = 32'd0;

  always #5 clk = ~clk;

  exu_lsu dut (
    .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .i_opcode(i_opcode),
    .i_funct3(i_funct3), .i_addr(i_addr), .i_wdata(i_wdata),
    .o_stall(o_stall), .o_rdata(o_rdata), .o_rdata_valid(o_rdata_valid),
    .o_misalign(o_misalign), .o_dmem_req(o_dmem_req), .o_dmem_we(o_dmem_we),
    .o_dmem_addr(o_dmem_addr), .o_dmem_be(o_dmem_be), .o_dmem_wdata(o_dmem_wdata),
    .i_dmem_gnt(i_dmem_gnt), .i_dmem_rvalid(i_dmem_rvalid), .i_dmem_rdata(i_dmem_rdata)
  );

  // kind: 0 store accepted, 1 load accepted, 2 load result, 3 misalign flag
  typedef struct {
    int          kind;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] data;
  } ev_t;

  ev_t expq[$];
  ev_t mon_e;
  int  total = 0;
  int  bad = 0;
  bit  mon_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every DUT-side event consumes the next expectation in order.
  always @(negedge clk) begin
    if (mon_en) begin
      if (!o_rdata_valid) chk("rdata_zero_when_invalid", o_rdata, 32'd0);
      if (o_dmem_req && i_dmem_gnt) begin
        if (expq.size() == 0) begin
          chk("unexpected_accept", 32'(o_dmem_we), 32'hFFFF_FFFF);
        end else begin
          mon_e = expq.pop_front();
          chk("accept_kind", o_dmem_we ? 32'd0 : 32'd1, 32'(mon_e.kind));
          chk("accept_addr", o_dmem_addr, mon_e.addr);
          if (o_dmem_we) begin
            chk("accept_be", 32'(o_dmem_be), 32'(mon_e.be));
            chk("accept_wdata", o_dmem_wdata, mon_e.wdata);
          end
        end
      end
      if (o_rdata_valid) begin
        if (expq.size() == 0) begin
          chk("unexpected_rdata", o_rdata, 32'hDEAD_0000);
        end else begin
          mon_e = expq.pop_front();
          chk("rdata_kind", 32'd2, 32'(mon_e.kind));
          chk("rdata_value", o_rdata, mon_e.data);
        end
      end
      if (o_misalign) begin
        if (expq.size() == 0) begin
          chk("unexpected_misalign", 32'd1, 32'd0);
        end else begin
          mon_e = expq.pop_front();
          chk("misalign_kind", 32'd3, 32'(mon_e.kind));
        end
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    i_valid       = 1'b0;
    i_dmem_gnt    = 1'b0;
    i_dmem_rvalid = 1'b0;
  endtask

  // One instruction: gd = cycles before grant, rd = WAIT cycles before rvalid.
  task automatic do_op(input logic [6:0] opc, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [31:0] rw, input int gd, input int rd);
    bit          ld, st, legal, mis, act;
    int          sz, off;
    logic [31:0] mask, v, expwd, waddr;
    logic [3:0]  expbe;
    ev_t         e;
    ld    = (opc == RV32_OPCODE_LOAD);
    st    = (opc == RV32_OPCODE_STORE);
    legal = (ld && (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5)) ||
            (st && f3 <= 3'd2);
    sz    = (f3 % 4 == 0) ? 1 : ((f3 % 4 == 1) ? 2 : 4);
    off   = int'(addr % 4);
    mis   = legal && (off % sz != 0);
    act   = legal && !mis;
    expbe = 4'(((1 << sz) - 1) << off);
    waddr = addr - 32'(off);
    if (sz == 1)      expwd = (wd & 32'hFF) * 32'h0101_0101;
    else if (sz == 2) expwd = (wd & 32'hFFFF) * 32'h0001_0001;
    else              expwd = wd;
    mask = (sz == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * sz)) - 32'd1);
    v    = (rw >> (8 * off)) & mask;
    if (f3 < 3'd4 && sz < 4 && ((v >> (8 * sz - 1)) & 32'd1) == 32'd1) v = v | ~mask;

    i_valid = 1'b1; i_opcode = opc; i_funct3 = f3; i_addr = addr; i_wdata = wd;
    if (!act) begin
      if (mis) begin
        e = '{kind: 3, addr: 32'd0, be: 4'd0, wdata: 32'd0, data: 32'd0};
        expq.push_back(e);
      end
      i_dmem_gnt    = 1'($urandom_range(0, 1));
      i_dmem_rvalid = 1'($urandom_range(0, 1));
      i_dmem_rdata  = $urandom;
      @(negedge clk);
      chk("noact_req", 32'(o_dmem_req), 32'd0);
      chk("noact_stall", 32'(o_stall), 32'd0);
      chk("misalign_flag", 32'(o_misalign), 32'(mis));
      next_cycle();
      idle_inputs();
      return;
    end
    e = '{kind: (st ? 0 : 1), addr: waddr, be: expbe, wdata: expwd, data: 32'd0};
    expq.push_back(e);
    if (ld) begin
      e = '{kind: 2, addr: waddr, be: expbe, wdata: 32'd0, data: v};
      expq.push_back(e);
    end
    for (int c = 0; c <= gd; c++) begin
      i_dmem_gnt    = (c == gd);
      i_dmem_rvalid = 1'($urandom_range(0, 1));
      i_dmem_rdata  = $urandom;
      @(negedge clk);
      chk("req_held", 32'(o_dmem_req), 32'd1);
      chk("req_we", 32'(o_dmem_we), 32'(st));
      chk("req_addr_stable", o_dmem_addr, waddr);
      if (st) begin
        chk("req_be_stable", 32'(o_dmem_be), 32'(expbe));
        chk("req_wdata_stable", o_dmem_wdata, expwd);
      end
      chk("req_stall", 32'(o_stall), 32'(!(st && c == gd)));
      next_cycle();
    end
    i_dmem_gnt = 1'b0;
    if (ld) begin
      for (int c = 0; c <= rd; c++) begin
        i_dmem_gnt    = 1'($urandom_range(0, 1));
        i_dmem_rvalid = (c == rd);
        i_dmem_rdata  = (c == rd) ? rw : $urandom;
        @(negedge clk);
        chk("wait_stall", 32'(o_stall), 32'(c != rd));
        chk("wait_no_req", 32'(o_dmem_req), 32'd0);
        next_cycle();
      end
    end
    idle_inputs();
  endtask

  logic [6:0] other_ops [3] = '{7'b0110011, 7'b0010011, 7'b1100011};

  initial begin
    logic [6:0] opc;
    // Reset held with live, legal and misaligned requests on the inputs.
    #1;
    i_valid = 1'b1; i_opcode = RV32_OPCODE_STORE; i_funct3 = F3_SW;
    i_addr = 32'h100; i_wdata = 32'h1234_5678; i_dmem_gnt = 1'b1; i_dmem_rvalid = 1'b1;
    @(negedge clk);
    chk("rst_req", 32'(o_dmem_req), 32'd0);
    chk("rst_stall", 32'(o_stall), 32'd0);
    chk("rst_rdata_valid", 32'(o_rdata_valid), 32'd0);
    chk("rst_rdata", o_rdata, 32'd0);
    next_cycle();
    i_opcode = RV32_OPCODE_LOAD; i_funct3 = F3_LH; i_addr = 32'h201;
    @(negedge clk);
    chk("rst_misalign", 32'(o_misalign), 32'd0);
    chk("rst_stall2", 32'(o_stall), 32'd0);
    next_cycle();
    rst_n = 1'b1;
    idle_inputs();
    mon_en = 1'b1;
    next_cycle();

    // Directed scenarios from the block description.
    do_op(RV32_OPCODE_STORE, F3_SW, 32'h100, 32'hDEAD_BEEF, 32'd0, 0, 0);
    do_op(RV32_OPCODE_STORE, F3_SB, 32'h103, 32'h0000_00A5, 32'd0, 2, 0);
    do_op(RV32_OPCODE_LOAD,  F3_LB, 32'h202, 32'd0, 32'h12F0_3456, 0, 0);
    do_op(RV32_OPCODE_LOAD,  F3_LBU, 32'h202, 32'd0, 32'h12F0_3456, 0, 0);
    do_op(RV32_OPCODE_LOAD,  F3_LH, 32'h201, 32'd0, 32'd0, 0, 0);

    // LW abandoned by reset while waiting; the stray rvalid afterwards is ignored.
    e_push_lw_accept();
    i_valid = 1'b1; i_opcode = RV32_OPCODE_LOAD; i_funct3 = F3_LW; i_addr = 32'h300;
    i_dmem_gnt = 1'b1;
    @(negedge clk);
    chk("lw_rst_req", 32'(o_dmem_req), 32'd1);
    chk("lw_rst_stall", 32'(o_stall), 32'd1);
    next_cycle();
    i_dmem_gnt = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    chk("lw_rst_stall_forced", 32'(o_stall), 32'd0);
    chk("lw_rst_rvalid_forced", 32'(o_rdata_valid), 32'd0);
    next_cycle();
    rst_n = 1'b1; i_valid = 1'b0; i_dmem_rvalid = 1'b1; i_dmem_rdata = 32'hCAFE_F00D;
    @(negedge clk);
    chk("stray_rvalid_ignored", 32'(o_rdata_valid), 32'd0);
    chk("stray_rvalid_stall", 32'(o_stall), 32'd0);
    next_cycle();
    idle_inputs();
    // A fresh store granted at once proves the FSM is back in IDLE.
    do_op(RV32_OPCODE_STORE, F3_SH, 32'h402, 32'h0000_BEEF, 32'd0, 0, 0);

    // Randomized traffic.
    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(0, 4))
        0, 1:    opc = RV32_OPCODE_LOAD;
        2, 3:    opc = RV32_OPCODE_STORE;
        default: opc = other_ops[$urandom_range(0, 2)];
      endcase
      do_op(opc, 3'($urandom_range(0, 7)), $urandom, $urandom, $urandom,
            int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
      repeat ($urandom_range(0, 2)) next_cycle();
    end

    repeat (3) next_cycle();
    chk("queue_drained", 32'(expq.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  task automatic e_push_lw_accept();
    ev_t e;
    e = '{kind: 1, addr: 32'h300, be: 4'hF, wdata: 32'd0, data: 32'd0};
    expq.push_back(e);
  endtask

endmodule
